eth_rx_header_decoder: RTL

- Sits directly downstream of the tri-speed MAC RX output, in the GMII RX clock domain.
- Strips the 14-byte Ethernet II header (dst MAC, src MAC, ethertype) and filters frames on destination address.
- Realigns the payload to 32-bit word boundaries and forwards it, with header fields, to the layer-3 stack using the same start/data/commit/drop protocol.

---
 rtl/eth_rx_header_decoder.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/eth_rx_header_decoder.sv
// rtl/eth_rx_header_decoder.sv - Ethernet II header strip, destination filter and 32-bit payload realignment
module eth_rx_header_decoder #(
    parameter bit ALLOW_RUNT_COUNT_WRAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] our_mac,
    input  logic        promisc,
    input  logic        accept_multicast,
    input  logic        rx_start,
    input  logic        rx_data_valid,
    input  logic [2:0]  rx_bytes_valid,
    input  logic [31:0] rx_data,
    input  logic        rx_commit,
    input  logic        rx_drop,
    output logic        l3_start,
    output logic [15:0] l3_ethertype,
    output logic [47:0] l3_src_mac,
    output logic [47:0] l3_dst_mac,
    output logic        l3_data_valid,
    output logic [2:0]  l3_bytes_valid,
    output logic [31:0] l3_data,
    output logic        l3_commit,
    output logic        l3_drop,
    output logic [15:0] rejected_count,
    output logic [15:0] runt_count
);
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_BODY, S_FLUSH, S_SKIP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  widx_q, widx_d;
    logic [47:0] dst_q, dst_d;
    logic [47:0] src_q, src_d;
    logic [23:0] res_q, res_d;
    logic [1:0]  rc_q, rc_d;
    logic        commit_pend_q, commit_pend_d;

    logic        start_q, start_d;
    logic [15:0] etype_q, etype_d;
    logic [47:0] osrc_q, osrc_d;
    logic [47:0] odst_q, odst_d;
    logic        dv_q, dv_d;
    logic [2:0]  bv_q, bv_d;
    logic [31:0] data_q, data_d;
    logic        commit_q, commit_d;
    logic        drop_q, drop_d;
    logic [15:0] rej_q, rej_d;
    logic [15:0] runt_q, runt_d;

    logic [47:0] dst_full;
    logic        addr_pass;
    logic [31:0] data_mask;
    logic [55:0] merged;
    logic [2:0]  total;

    function automatic logic [15:0] bump(input logic [15:0] v);
        if (ALLOW_RUNT_COUNT_WRAP)
            return v + 16'd1;
        return (v == 16'hffff) ? v : v + 16'd1;
    endfunction

    // Residue bytes sit at the top of the merge window; new data is slid in right behind them.
    always_comb begin
        dst_full  = {dst_q[47:16], rx_data[31:16]};
        addr_pass = promisc || (dst_full == our_mac) || (dst_full == 48'hffff_ffff_ffff) ||
                    (accept_multicast && dst_full[40]);
        case (rx_bytes_valid)
            3'd1:    data_mask = 32'hff00_0000;
            3'd2:    data_mask = 32'hffff_0000;
            3'd3:    data_mask = 32'hffff_ff00;
            default: data_mask = 32'hffff_ffff;
        endcase
        merged = {res_q, 32'h0} | ({rx_data & data_mask, 24'h0} >> {rc_q, 3'b000});
        total  = {1'b0, rc_q} + rx_bytes_valid;
    end

    always_comb begin
        state_d       = state_q;
        widx_d        = widx_q;
        dst_d         = dst_q;
        src_d         = src_q;
        res_d         = res_q;
        rc_d          = rc_q;
        commit_pend_d = 1'b0;
        start_d       = 1'b0;
        etype_d       = etype_q;
        osrc_d        = osrc_q;
        odst_d        = odst_q;
        dv_d          = 1'b0;
        bv_d          = bv_q;
        data_d        = data_q;
        drop_d        = 1'b0;
        rej_d         = rej_q;
        runt_d        = runt_q;
        // A frame that reaches FLUSH and is then overtaken by a new start is dropped, not committed.
        commit_d      = commit_pend_q && !(state_q == S_FLUSH && rx_start);

        case (state_q)
            S_HDR: begin
                if (rx_commit || rx_drop) begin
                    runt_d  = bump(runt_q);
                    state_d = S_IDLE;
                end else if (rx_data_valid && !rx_start) begin
                    case (widx_q)
                        2'd0: begin
                            dst_d[47:16] = rx_data;
                            widx_d       = 2'd1;
                        end
                        2'd1: begin
                            dst_d[15:0]  = rx_data[31:16];
                            src_d[47:32] = rx_data[15:0];
                            if (addr_pass) begin
                                widx_d = 2'd2;
                            end else begin
                                rej_d   = bump(rej_q);
                                state_d = S_SKIP;
                            end
                        end
                        2'd2: begin
                            src_d[31:0] = rx_data;
                            widx_d      = 2'd3;
                        end
                        default: begin
                            start_d = 1'b1;
                            odst_d  = dst_q;
                            osrc_d  = src_q;
                            etype_d = rx_data[31:16];
                            if (rx_bytes_valid == 3'd4) begin
                                res_d = {rx_data[15:0], 8'h0};
                                rc_d  = 2'd2;
                            end else begin
                                res_d = 24'h0;
                                rc_d  = 2'd0;
                            end
                            state_d = S_BODY;
                        end
                    endcase
                end
            end
            S_BODY: begin
                if (rx_drop) begin
                    drop_d  = 1'b1;
                    res_d   = 24'h0;
                    rc_d    = 2'd0;
                    state_d = S_IDLE;
                end else if (rx_commit) begin
                    if (rc_q != 2'd0) begin
                        dv_d          = 1'b1;
                        bv_d          = {1'b0, rc_q};
                        data_d        = {res_q, 8'h0};
                        commit_pend_d = 1'b1;
                        state_d       = S_FLUSH;
                    end else begin
                        commit_d = 1'b1;
                        state_d  = S_IDLE;
                    end
                    res_d = 24'h0;
                    rc_d  = 2'd0;
                end else if (rx_data_valid && !rx_start) begin
                    if (total >= 3'd4) begin
                        dv_d   = 1'b1;
                        bv_d   = 3'd4;
                        data_d = merged[55:24];
                        res_d  = merged[23:0];
                    end else begin
                        res_d = merged[55:32];
                    end
                    rc_d = total[1:0];
                end
            end
            S_FLUSH: state_d = S_IDLE;
            S_SKIP: begin
                if (rx_commit || rx_drop)
                    state_d = S_IDLE;
            end
            default: ;
        endcase

        if (rx_start) begin
            if ((state_q == S_BODY && !rx_commit && !rx_drop) || state_q == S_FLUSH)
                drop_d = 1'b1;
            widx_d  = 2'd0;
            res_d   = 24'h0;
            rc_d    = 2'd0;
            state_d = S_HDR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            widx_q        <= 2'd0;
            dst_q         <= 48'h0;
            src_q         <= 48'h0;
            res_q         <= 24'h0;
            rc_q          <= 2'd0;
            commit_pend_q <= 1'b0;
            start_q       <= 1'b0;
            etype_q       <= 16'h0;
            osrc_q        <= 48'h0;
            odst_q        <= 48'h0;
            dv_q          <= 1'b0;
            bv_q          <= 3'd0;
            data_q        <= 32'h0;
            commit_q      <= 1'b0;
            drop_q        <= 1'b0;
            rej_q         <= 16'h0;
            runt_q        <= 16'h0;
        end else begin
            state_q       <= state_d;
            widx_q        <= widx_d;
            dst_q         <= dst_d;
            src_q         <= src_d;
            res_q         <= res_d;
            rc_q          <= rc_d;
            commit_pend_q <= commit_pend_d;
            start_q       <= start_d;
            etype_q       <= etype_d;
            osrc_q        <= osrc_d;
            odst_q        <= odst_d;
            dv_q          <= dv_d;
            bv_q          <= bv_d;
            data_q        <= data_d;
            commit_q      <= commit_d;
            drop_q        <= drop_d;
            rej_q         <= rej_d;
            runt_q        <= runt_d;
        end
    end

    assign l3_start       = start_q;
    assign l3_ethertype   = etype_q;
    assign l3_src_mac     = osrc_q;
    assign l3_dst_mac     = odst_q;
    assign l3_data_valid  = dv_q;
    assign l3_bytes_valid = bv_q;
    assign l3_data        = data_q;
    assign l3_commit      = commit_q;
    assign l3_drop        = drop_q;
    assign rejected_count = rej_q;
    assign runt_count     = runt_q;
endmodule
